shift_arbiter: RTL and testbench



---
 rtl/shift_arbiter_pkg.sv | 20 ++
 rtl/shift_arbiter_core.sv | 35 +++
 rtl/shift_arbiter.sv | 142 ++++++++++++++
 tb/tb_shift_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the shift arbiter: opcodes, FSM state encodings and default widths.
// Optional rotate support is selected by SHIFT_ARB_ROTATE_EN (see shift_arbiter_core).
package shift_arbiter_pkg;

    localparam int WIDTH_DEF   = 32;
    localparam int SHAMT_W_DEF = 5;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } shift_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/shift_arbiter_core.sv
// Combinational 32-bit shifter: SLL/SRL/SRA, and ROR when SHIFT_ARB_ROTATE_EN is defined
// (otherwise op 11 behaves as SRL). Only the low SHAMT_W bits of b are used.
module shift_arbiter_core
    import shift_arbiter_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] res
);

    logic [SHAMT_W-1:0] shamt_s;

    // Shift result selected by opcode; rotate is a shift of the doubled operand.
    always_comb begin
        shamt_s = SHAMT_W'(b);
        case (op)
            OP_SLL:  res = a << shamt_s;
            OP_SRL:  res = a >> shamt_s;
            OP_SRA:  res = WIDTH'($signed(a) >>> shamt_s);
            OP_ROR: begin
`ifdef SHIFT_ARB_ROTATE_EN
                res = WIDTH'({a, a} >> shamt_s);
`else
                res = a >> shamt_s;
`endif
            end
            default: res = a >> shamt_s;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shifter between two requesters, one outstanding result.
// Build option: SHIFT_ARB_ROTATE_EN enables op 11 as rotate-right inside shift_arbiter_core.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    state_e           state_q, state_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic             owner_q, owner_d;
    logic             rsp0_valid_q, rsp0_valid_d;
    logic             rsp1_valid_q, rsp1_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic             owner_ready_s;
    logic             arb_en_s;
    logic             grant0_s;
    logic             grant1_s;
    logic             accept_s;
    logic [1:0]       req_op_s;
    logic [WIDTH-1:0] req_a_s;
    logic [WIDTH-1:0] req_b_s;
    logic [WIDTH-1:0] shift_res_s;

    shift_arbiter_core #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_core (
        .a   (req_a_s),
        .b   (req_b_s),
        .op  (req_op_s),
        .res (shift_res_s)
    );

    // State, pointer, owner and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= 1'b0;
            owner_q      <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp_data_q   <= {WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    // Arbitration and request-ready outputs; HOLD arbitrates only when the held result drains.
    always_comb begin
        if (owner_q) begin
            owner_ready_s = rsp1_ready;
        end else begin
            owner_ready_s = rsp0_ready;
        end
        arb_en_s = (state_q == S_IDLE) || ((state_q == S_HOLD) && owner_ready_s);
        if (req0_valid && req1_valid) begin
            grant0_s = ~rr_ptr_q;
            grant1_s = rr_ptr_q;
        end else begin
            grant0_s = req0_valid;
            grant1_s = req1_valid;
        end
        req0_ready = arb_en_s & grant0_s;
        req1_ready = arb_en_s & grant1_s;
        accept_s   = (req0_valid & req0_ready) | (req1_valid & req1_ready);
        if (grant1_s) begin
            req_op_s = req1_op;
            req_a_s  = req1_a;
            req_b_s  = req1_b;
        end else begin
            req_op_s = req0_op;
            req_a_s  = req0_a;
            req_b_s  = req0_b;
        end
    end

    // Next-state: load on accept, drain to IDLE on response acceptance, else hold.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;
        rsp_data_d   = rsp_data_q;
        case (state_q)
            S_IDLE, S_HOLD: begin
                if (accept_s) begin
                    state_d      = S_HOLD;
                    rsp_data_d   = shift_res_s;
                    owner_d      = grant1_s;
                    rr_ptr_d     = ~grant1_s;
                    rsp0_valid_d = ~grant1_s;
                    rsp1_valid_d = grant1_s;
                end else if ((state_q == S_HOLD) && owner_ready_s) begin
                    state_d      = S_IDLE;
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                end else begin
                    state_d      = state_q;
                end
            end
            default: begin
                state_d      = S_IDLE;
                rsp0_valid_d = 1'b0;
                rsp1_valid_d = 1'b0;
            end
        endcase
    end

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp_data   = rsp_data_q;
    assign busy       = (state_q == S_HOLD);

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: vector table, scoreboard of accepted requests, corner sequences.
module tb_shift_arbiter;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_op = 2'b00, req1_op = 2'b00;
    logic [31:0] req0_a = 32'h0, req0_b = 32'h0, req1_a = 32'h0, req1_b = 32'h0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        busy;

    logic [31:0] tb_exp0 = 32'h0, tb_exp1 = 32'h0;
    exp_t        sb_q[$];
    int          tests = 0;
    int          fails = 0;
    vec_t        vecs[11];

    shift_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; tb_exp0 = exp;
    endtask

    task automatic drive1(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; tb_exp1 = exp;
    endtask

    task automatic pop_check(input logic port);
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("sb_port", {31'd0, port}, {31'd0, e.port});
            check("sb_data", rsp_data, e.data);
        end
    endtask

    // Scoreboard: pop on response handshake, push on request handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp0_valid && rsp1_valid) check("rsp_onehot", 32'd1, 32'd0);
            if (rsp0_valid && rsp0_ready) pop_check(1'b0);
            if (rsp1_valid && rsp1_ready) pop_check(1'b1);
            if (req0_valid && req0_ready) sb_q.push_back('{port: 1'b0, data: tb_exp0});
            if (req1_valid && req1_ready) sb_q.push_back('{port: 1'b1, data: tb_exp1});
        end
    end

    initial begin
        vecs[0]  = '{2'b00, 32'h0000_0001, 32'd31,        32'h8000_0000};
        vecs[1]  = '{2'b00, 32'h1234_5678, 32'd0,         32'h1234_5678};
        vecs[2]  = '{2'b01, 32'h1234_5678, 32'd0,         32'h1234_5678};
        vecs[3]  = '{2'b10, 32'h8765_4321, 32'd0,         32'h8765_4321};
        vecs[4]  = '{2'b10, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF};
        vecs[5]  = '{2'b01, 32'h8000_0000, 32'd31,        32'h0000_0001};
        vecs[6]  = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0024, 32'hFFFF_FFF0};
        vecs[7]  = '{2'b10, 32'h7FFF_FFFF, 32'd4,         32'h07FF_FFFF};
        vecs[8]  = '{2'b01, 32'hF000_0000, 32'h0000_0041, 32'h7800_0000};
`ifdef SHIFT_ARB_ROTATE_EN
        vecs[9]  = '{2'b11, 32'h0000_00F1, 32'd4,         32'h1000_000F};
`else
        vecs[9]  = '{2'b11, 32'h0000_00F1, 32'd4,         32'h0000_000F};
`endif
        vecs[10] = '{2'b11, 32'h1234_5678, 32'hFFFF_FFE0, 32'h1234_5678};

        // Reset state
        #12;
        check("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        check("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Port 0 SRL with upper shift bits ignored
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        drive0(2'b01, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000);
        #1 check("t1_req0_ready", {31'd0, req0_ready}, 32'd1);
        step();
        req0_valid = 1'b0;
        check("t1_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        check("t1_rsp_data", rsp_data, 32'h0800_0000);
        step();
        check("t1_idle", {31'd0, busy}, 32'd0);

        // Port 1 SRA held for three cycles while port 0 waits
        rsp1_ready = 1'b0;
        drive1(2'b10, 32'h8000_0000, 32'd4, 32'hF800_0000);
        step();
        req1_valid = 1'b0;
        drive0(2'b00, 32'h0000_0003, 32'd1, 32'h0000_0006);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t2_hold_data", rsp_data, 32'hF800_0000);
            check("t2_hold_busy", {31'd0, busy}, 32'd1);
            check("t2_hold_rsp1", {31'd0, rsp1_valid}, 32'd1);
            check("t2_req0_blocked", {31'd0, req0_ready}, 32'd0);
            step();
        end
        req0_valid = 1'b0;
        rsp1_ready = 1'b1;
        step();
        check("t2_idle_busy", {31'd0, busy}, 32'd0);
        check("t2_idle_rsp1", {31'd0, rsp1_valid}, 32'd0);

        // Both valid every cycle: grants alternate starting with port 0
        for (int k = 0; k < 6; k++) begin
            drive0(2'b00, 32'(k + 1), 32'd1, 32'((k + 1) * 2));
            drive1(2'b01, 32'((k + 1) * 256), 32'd4, 32'((k + 1) * 16));
            #1;
            check("t3_grant0", {31'd0, req0_ready}, {31'd0, ~k[0]});
            check("t3_grant1", {31'd0, req1_ready}, {31'd0, k[0]});
            step();
            check("t3_busy", {31'd0, busy}, 32'd1);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        check("t3_drain", {31'd0, busy}, 32'd0);

        // Vector table, back-to-back on port 0
        for (int i = 0; i < 11; i++) begin
            drive0(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
            step();
            check($sformatf("vec%0d", i), rsp_data, vecs[i].exp);
        end
        req0_valid = 1'b0;
        step();

        // Async reset during HOLD, then port 0 has priority again
        rsp1_ready = 1'b0;
        drive1(2'b00, 32'h0000_0001, 32'd4, 32'h0000_0010);
        step();
        drive0(2'b00, 32'h0000_0001, 32'd2, 32'h0000_0004);
        check("t5_hold", {31'd0, rsp1_valid}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t5_rst_rsp1", {31'd0, rsp1_valid}, 32'd0);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        sb_q.delete();
        step();
        rst_n = 1'b1;
        #1;
        check("t5_prio0", {31'd0, req0_ready}, 32'd1);
        check("t5_prio1", {31'd0, req1_ready}, 32'd0);
        rsp0_ready = 1'b1;
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("t5_rsp0", {31'd0, rsp0_valid}, 32'd1);
        check("t5_data", rsp_data, 32'h0000_0004);
        step();
        step();
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
